alu_issue_ctrl: RTL and testbench

Issue-side controller for the N-bit ALU datapath: accepts instructions over a valid/ready handshake, decodes them into the three ALU opcode select lines, presents operands from a 4-entry register file, and captures the ALU's selected result back into the register file. It is the counterpart of the ALU output selector: it produces the `aop2..aop0` select and consumes the selected result. It sits between the lab's instruction source and the ALU/result-mux datapath.

---
 rtl/alu_issue_ctrl_pkg.sv | 13 +
 rtl/alu_issue_ctrl_regfile.sv | 30 +++
 rtl/alu_issue_ctrl.sv | 67 ++++++
 tb/tb_alu_issue_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: opcode map, FSM state encoding and register index width shared by the issue controller
package alu_issue_ctrl_pkg;
   localparam int RIDX_W = 2;
   localparam logic [2:0] OP_MOV = 3'b000;
   localparam logic [2:0] OP_NOT = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_AND = 3'b101;
   localparam logic [2:0] OP_SLT = 3'b110;
   localparam logic [2:0] OP_ILL = 3'b111;
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;
endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// alu_regfile: 4-entry register file, two combinational read ports, write-back port overrides load port
import alu_issue_ctrl_pkg::*;
module alu_regfile #(
   parameter int Nsize = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [RIDX_W-1:0] ra_addr,
   input  logic [RIDX_W-1:0] rb_addr,
   output logic [Nsize-1:0]  ra_data,
   output logic [Nsize-1:0]  rb_data,
   input  logic              ld_en,
   input  logic [RIDX_W-1:0] ld_addr,
   input  logic [Nsize-1:0]  ld_data,
   input  logic              wb_en,
   input  logic [RIDX_W-1:0] wb_addr,
   input  logic [Nsize-1:0]  wb_wdata
);
   logic [Nsize-1:0] mem [4];
   assign ra_data = mem[ra_addr];
   assign rb_data = mem[rb_addr];
   // later nonblocking write lands last, so write-back wins a same-address collision
   always_ff @(posedge clk)
      if (reset) begin
         for (int i = 0; i < 4; i++) mem[i] <= '0;
      end else begin
         if (ld_en) mem[ld_addr] <= ld_data;
         if (wb_en) mem[wb_addr] <= wb_wdata;
      end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts instructions, drives ALU select/operands, writes the result back; op 111 traps sticky when ALU_ISSUE_ILLEGAL_TRAP_EN is defined
import alu_issue_ctrl_pkg::*;
module alu_issue_ctrl #(
   parameter int Nsize = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [2:0]        instr_op,
   input  logic [RIDX_W-1:0] instr_rd,
   input  logic [RIDX_W-1:0] instr_rs,
   input  logic [RIDX_W-1:0] instr_rt,
   input  logic              load_en,
   input  logic [RIDX_W-1:0] load_addr,
   input  logic [Nsize-1:0]  load_data,
   output logic              aop2,
   output logic              aop1,
   output logic              aop0,
   output logic [Nsize-1:0]  alu_a,
   output logic [Nsize-1:0]  alu_b,
   input  logic [Nsize-1:0]  alu_result,
   output logic              wb_valid,
   output logic [RIDX_W-1:0] wb_rd,
   output logic [Nsize-1:0]  wb_data,
   output logic              illegal
);
   state_t state;
   logic [2:0] op_q;
   logic [RIDX_W-1:0] rd_q, rs_q, rt_q;
   logic [Nsize-1:0] rf_a, rf_b;
   logic accept;
   assign instr_ready = state != S_EXEC && !illegal;
   assign accept = instr_valid && instr_ready;
   assign {aop2, aop1, aop0} = op_q;
   assign alu_a = state == S_EXEC ? rf_a : '0;
   assign alu_b = state == S_EXEC ? rf_b : '0;
   alu_regfile #(.Nsize(Nsize)) u_rf (
      .clk(clk), .reset(reset),
      .ra_addr(rs_q), .rb_addr(rt_q), .ra_data(rf_a), .rb_data(rf_b),
      .ld_en(load_en), .ld_addr(load_addr), .ld_data(load_data),
      .wb_en(wb_valid), .wb_addr(wb_rd), .wb_wdata(wb_data)
   );
   // wb_data doubles as the result register captured at the end of EXEC
   always_ff @(posedge clk)
      if (reset) begin
         state <= S_IDLE;
         op_q <= '0;
         rd_q <= '0;
         rs_q <= '0;
         rt_q <= '0;
         wb_valid <= 1'b0;
         wb_rd <= '0;
         wb_data <= '0;
      end else begin
         state <= accept ? S_EXEC : state == S_EXEC ? S_WB : S_IDLE;
         wb_valid <= state == S_EXEC && op_q != OP_ILL;
         if (accept) {op_q, rd_q, rs_q, rt_q} <= {instr_op, instr_rd, instr_rs, instr_rt};
         if (state == S_EXEC && op_q != OP_ILL) {wb_rd, wb_data} <= {rd_q, alu_result};
      end
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
   always_ff @(posedge clk)
      illegal <= reset ? 1'b0 : illegal | (accept && instr_op == OP_ILL);
`else
   assign illegal = 1'b0;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed scenario tasks against a behavioural ALU datapath model
module tb_alu_issue_ctrl;
   logic clk = 0, reset = 1;
   logic instr_valid = 0, instr_ready;
   logic [2:0] instr_op = 0;
   logic [1:0] instr_rd = 0, instr_rs = 0, instr_rt = 0;
   logic load_en = 0;
   logic [1:0] load_addr = 0;
   logic [2:0] load_data = 0;
   logic aop2, aop1, aop0;
   logic [2:0] alu_a, alu_b, alu_result;
   logic wb_valid;
   logic [1:0] wb_rd;
   logic [2:0] wb_data;
   logic illegal;
   int checks = 0, errors = 0;

   alu_issue_ctrl #(.Nsize(3)) dut (
      .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs), .instr_rt(instr_rt),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .aop2(aop2), .aop1(aop1), .aop0(aop0), .alu_a(alu_a), .alu_b(alu_b),
      .alu_result(alu_result), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .illegal(illegal)
   );

   always #5 clk = ~clk;

   // behavioural ALU + result selector standing in for the datapath
   always_comb begin
      alu_result = '0;
      case ({aop2, aop1, aop0})
         3'b000: alu_result = alu_a;
         3'b001: alu_result = ~alu_a;
         3'b010: alu_result = alu_a + alu_b;
         3'b011: alu_result = alu_a - alu_b;
         3'b100: alu_result = alu_a | alu_b;
         3'b101: alu_result = alu_a & alu_b;
         3'b110: alu_result = {2'b00, alu_a < alu_b};
         default: alu_result = '0;
      endcase
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [1:0] rt);
      instr_valid = 1;
      instr_op = op;
      instr_rd = rd;
      instr_rs = rs;
      instr_rt = rt;
   endtask

   task automatic load(input logic [1:0] a, input logic [2:0] d);
      load_en = 1;
      load_addr = a;
      load_data = d;
      step();
      load_en = 0;
   endtask

   task automatic test_reset();
      reset = 1;
      step();
      step();
      reset = 0;
      step();
      checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", instr_ready); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
      checks++; if ({wb_rd, wb_data} !== 5'd0) begin errors++; $display("FAIL reset_wb got rd %0d data %0d exp 0 0", wb_rd, wb_data); end
      checks++; if ({aop2, aop1, aop0} !== 3'b000) begin errors++; $display("FAIL reset_aop got %b exp 000", {aop2, aop1, aop0}); end
      checks++; if ({alu_a, alu_b} !== 6'd0) begin errors++; $display("FAIL reset_operands got %0d %0d exp 0 0", alu_a, alu_b); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", illegal); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (dut.u_rf.mem[i] !== 3'd0) begin errors++; $display("FAIL reset_rf%0d got %0d exp 0", i, dut.u_rf.mem[i]); end
      end
   endtask

   task automatic test_add();
      load(2'd1, 3'd3);
      load(2'd2, 3'd2);
      offer(3'b010, 2'd3, 2'd1, 2'd2);
      step();
      instr_valid = 0;
      checks++; if ({aop2, aop1, aop0} !== 3'b010) begin errors++; $display("FAIL add_aop got %b exp 010", {aop2, aop1, aop0}); end
      checks++; if ({alu_a, alu_b} !== {3'd3, 3'd2}) begin errors++; $display("FAIL add_operands got %0d %0d exp 3 2", alu_a, alu_b); end
      checks++; if (instr_ready !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL add_exec got ready %b wb_valid %b exp 0 0", instr_ready, wb_valid); end
      step();
      checks++; if (wb_valid !== 1'b1 || wb_rd !== 2'd3 || wb_data !== 3'd5) begin errors++; $display("FAIL add_wb got v %b rd %0d data %0d exp 1 3 5", wb_valid, wb_rd, wb_data); end
      checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL add_wb_ready got %b exp 1", instr_ready); end
      checks++; if ({alu_a, alu_b} !== 6'd0) begin errors++; $display("FAIL add_wb_operands got %0d %0d exp 0 0", alu_a, alu_b); end
      step();
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL add_pulse got %b exp 0", wb_valid); end
      checks++; if (dut.u_rf.mem[3] !== 3'd5) begin errors++; $display("FAIL add_rf3 got %0d exp 5", dut.u_rf.mem[3]); end
   endtask

   task automatic test_back_to_back();
      offer(3'b011, 2'd1, 2'd3, 2'd1);
      step();
      offer(3'b000, 2'd0, 2'd1, 2'd0);
      checks++; if (instr_ready !== 1'b0 || {aop2, aop1, aop0} !== 3'b011) begin errors++; $display("FAIL b2b_exec1 got ready %b aop %b exp 0 011", instr_ready, {aop2, aop1, aop0}); end
      checks++; if ({alu_a, alu_b} !== {3'd5, 3'd3}) begin errors++; $display("FAIL b2b_sub_operands got %0d %0d exp 5 3", alu_a, alu_b); end
      step();
      checks++; if (wb_valid !== 1'b1 || wb_rd !== 2'd1 || wb_data !== 3'd2) begin errors++; $display("FAIL b2b_wb1 got v %b rd %0d data %0d exp 1 1 2", wb_valid, wb_rd, wb_data); end
      checks++; if (instr_ready !== 1'b1 || {aop2, aop1, aop0} !== 3'b011) begin errors++; $display("FAIL b2b_held got ready %b aop %b exp 1 011", instr_ready, {aop2, aop1, aop0}); end
      step();
      instr_valid = 0;
      checks++; if ({aop2, aop1, aop0} !== 3'b000 || alu_a !== 3'd2 || wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_exec2 got aop %b a %0d v %b exp 000 2 0", {aop2, aop1, aop0}, alu_a, wb_valid); end
      step();
      checks++; if (wb_valid !== 1'b1 || wb_rd !== 2'd0 || wb_data !== 3'd2) begin errors++; $display("FAIL b2b_wb2 got v %b rd %0d data %0d exp 1 0 2", wb_valid, wb_rd, wb_data); end
      step();
      checks++; if (dut.u_rf.mem[0] !== 3'd2 || dut.u_rf.mem[1] !== 3'd2) begin errors++; $display("FAIL b2b_rf got rf0 %0d rf1 %0d exp 2 2", dut.u_rf.mem[0], dut.u_rf.mem[1]); end
   endtask

   task automatic test_wb_priority();
      offer(3'b010, 2'd3, 2'd0, 2'd1);
      step();
      instr_valid = 0;
      step();
      checks++; if (wb_valid !== 1'b1 || wb_data !== 3'd4) begin errors++; $display("FAIL prio_wb got v %b data %0d exp 1 4", wb_valid, wb_data); end
      load(2'd3, 3'd7);
      checks++; if (dut.u_rf.mem[3] !== 3'd4) begin errors++; $display("FAIL prio_rf3 got %0d exp 4", dut.u_rf.mem[3]); end
   endtask

   task automatic test_illegal();
      offer(3'b111, 2'd2, 2'd0, 2'd0);
      step();
      instr_valid = 0;
      checks++; if ({aop2, aop1, aop0} !== 3'b111) begin errors++; $display("FAIL ill_aop got %b exp 111", {aop2, aop1, aop0}); end
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      checks++; if (illegal !== 1'b1 || instr_ready !== 1'b0) begin errors++; $display("FAIL ill_trap got illegal %b ready %b exp 1 0", illegal, instr_ready); end
      step();
      checks++; if (wb_valid !== 1'b0 || instr_ready !== 1'b0) begin errors++; $display("FAIL ill_trap_wb got v %b ready %b exp 0 0", wb_valid, instr_ready); end
      offer(3'b001, 2'd2, 2'd3, 2'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         checks++; if (wb_valid !== 1'b0 || instr_ready !== 1'b0) begin errors++; $display("FAIL ill_blocked got v %b ready %b exp 0 0", wb_valid, instr_ready); end
      end
      instr_valid = 0;
      load(2'd1, 3'd6);
      checks++; if (dut.u_rf.mem[1] !== 3'd6 || dut.u_rf.mem[2] !== 3'd2) begin errors++; $display("FAIL ill_load got rf1 %0d rf2 %0d exp 6 2", dut.u_rf.mem[1], dut.u_rf.mem[2]); end
`else
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_flag got %b exp 0", illegal); end
      step();
      checks++; if (wb_valid !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL ill_wb got v %b ready %b exp 0 1", wb_valid, instr_ready); end
      step();
      checks++; if (dut.u_rf.mem[2] !== 3'd2 || wb_valid !== 1'b0) begin errors++; $display("FAIL ill_rf2 got %0d v %b exp 2 0", dut.u_rf.mem[2], wb_valid); end
      offer(3'b001, 2'd2, 2'd3, 2'd0);
      step();
      instr_valid = 0;
      step();
      checks++; if (wb_valid !== 1'b1 || wb_rd !== 2'd2 || wb_data !== 3'd3) begin errors++; $display("FAIL ill_next got v %b rd %0d data %0d exp 1 2 3", wb_valid, wb_rd, wb_data); end
      step();
      checks++; if (dut.u_rf.mem[2] !== 3'd3) begin errors++; $display("FAIL ill_next_rf2 got %0d exp 3", dut.u_rf.mem[2]); end
`endif
   endtask

   task automatic test_reset_exec();
      reset = 1;
      step();
      reset = 0;
      load(2'd1, 3'd3);
      load(2'd2, 3'd2);
      offer(3'b010, 2'd3, 2'd1, 2'd2);
      step();
      instr_valid = 0;
      checks++; if (alu_a !== 3'd3 || instr_ready !== 1'b0) begin errors++; $display("FAIL rst_exec_pre got a %0d ready %b exp 3 0", alu_a, instr_ready); end
      reset = 1;
      step();
      reset = 0;
      checks++; if (wb_valid !== 1'b0 || instr_ready !== 1'b1 || alu_a !== 3'd0) begin errors++; $display("FAIL rst_exec got v %b ready %b a %0d exp 0 1 0", wb_valid, instr_ready, alu_a); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (dut.u_rf.mem[i] !== 3'd0) begin errors++; $display("FAIL rst_exec_rf%0d got %0d exp 0", i, dut.u_rf.mem[i]); end
      end
      step();
      checks++; if (wb_valid !== 1'b0 || dut.u_rf.mem[3] !== 3'd0) begin errors++; $display("FAIL rst_exec_after got v %b rf3 %0d exp 0 0", wb_valid, dut.u_rf.mem[3]); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_wb_priority();
      test_illegal();
      test_reset_exec();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
